// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one 64-bit pmem port between the icache and dcache.
// Whole cache lines are serialized into 4-beat bursts; one line transaction in flight at a time.
module pmem_arbiter #(
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ipmem_read,
   input  logic [31:0]       ipmem_address,
   output logic [LINE_W-1:0] ipmem_rdata,
   output logic              ipmem_resp,
   input  logic              dpmem_read,
   input  logic              dpmem_write,
   input  logic [31:0]       dpmem_address,
   input  logic [LINE_W-1:0] dpmem_wdata,
   output logic [LINE_W-1:0] dpmem_rdata,
   output logic              dpmem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       pmem_address,
   output logic [BEAT_W-1:0] pmem_wdata,
   input  logic [BEAT_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam logic [31:0] LINE_MASK = ~32'((1 << OFF_W) - 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      I_READ,
      D_READ,
      D_WRITE,
      I_DONE,
      D_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [LINE_W-1:0] line_reg, line_next;
   logic [31:0]       addr_reg, addr_next;
   logic              last_grant_reg, last_grant_next;

   logic              i_req, d_req, grant_d;
   logic              in_read, last_beat;
   logic [LINE_W-1:0] fill_line;
   logic [BEAT_W-1:0] line_beat [BEATS];

   // fill_line is the buffer with the current beat slot replaced by the incoming read beat
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
         assign line_beat[gi] = line_reg[gi*BEAT_W +: BEAT_W];
         assign fill_line[gi*BEAT_W +: BEAT_W] =
            (cnt_reg == CNT_W'(gi)) ? pmem_rdata : line_reg[gi*BEAT_W +: BEAT_W];
      end
   endgenerate

   assign i_req     = ipmem_read;
   assign d_req     = dpmem_read | dpmem_write;
   assign grant_d   = d_req & (~i_req | (last_grant_reg == GRANT_I));
   assign in_read   = (state_reg == I_READ) || (state_reg == D_READ);
   assign last_beat = (cnt_reg == LAST_BEAT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         line_reg       <= '0;
         addr_reg       <= '0;
         last_grant_reg <= GRANT_D;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         line_reg       <= line_next;
         addr_reg       <= addr_next;
         last_grant_reg <= last_grant_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      line_next       = line_reg;
      addr_next       = addr_reg;
      last_grant_next = last_grant_reg;
      case (state_reg)
         IDLE: begin
            if (i_req || d_req) begin
               cnt_next        = '0;
               last_grant_next = grant_d;
               if (grant_d) begin
                  addr_next = dpmem_address & LINE_MASK;
                  if (dpmem_write) begin
                     state_next = D_WRITE;
                     line_next  = dpmem_wdata;
                  end else begin
                     state_next = D_READ;
                  end
               end else begin
                  addr_next  = ipmem_address & LINE_MASK;
                  state_next = I_READ;
               end
            end
         end
         I_READ, D_READ: begin
            if (pmem_resp) begin
               line_next = fill_line;
               cnt_next  = cnt_reg + 1'b1;
               if (last_beat) begin
                  state_next = (state_reg == I_READ) ? I_DONE : D_DONE;
               end
            end
         end
         D_WRITE: begin
            if (pmem_resp) begin
               cnt_next = cnt_reg + 1'b1;
               if (last_beat) begin
                  state_next = D_DONE;
               end
            end
         end
         I_DONE, D_DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign pmem_read    = in_read;
   assign pmem_write   = (state_reg == D_WRITE);
   assign pmem_address = addr_reg;
   assign pmem_wdata   = (state_reg == D_WRITE) ? line_beat[cnt_reg] : '0;
   assign ipmem_resp   = (state_reg == I_DONE);
   assign dpmem_resp   = (state_reg == D_DONE);
   // Only the resp cycle is meaningful on the rdata outputs
   assign ipmem_rdata  = line_reg;
   assign dpmem_rdata  = line_reg;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: requester tasks push expected lines into per-cache queues,
// a pmem responder model serves bursts, and a monitor pops and compares on each resp.
module tb_pmem_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ipmem_read = 1'b0;
   logic [31:0]  ipmem_address = '0;
   logic [255:0] ipmem_rdata;
   logic         ipmem_resp;
   logic         dpmem_read = 1'b0;
   logic         dpmem_write = 1'b0;
   logic [31:0]  dpmem_address = '0;
   logic [255:0] dpmem_wdata = '0;
   logic [255:0] dpmem_rdata;
   logic         dpmem_resp;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [63:0]  pmem_wdata;
   logic [63:0]  pmem_rdata = '0;
   logic         pmem_resp = 1'b0;

   typedef struct packed {
      logic         w;
      logic [31:0]  addr;
      logic [255:0] data;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t iq[$];
   exp_t dq[$];
   int   order_q[$];
   int   resp_cyc_q[$];
   int   start_cyc_q[$];
   int   gap_fixed = 0;
   bit   gap_rand = 1'b0;
   int   budget = -1;
   logic         lb_w = 1'b0;
   logic [31:0]  lb_addr = '0;
   logic [255:0] lb_data = '0;
   int           lb_len = 0;

   pmem_arbiter dut (
      .clk(clk), .rst(rst),
      .ipmem_read(ipmem_read), .ipmem_address(ipmem_address),
      .ipmem_rdata(ipmem_rdata), .ipmem_resp(ipmem_resp),
      .dpmem_read(dpmem_read), .dpmem_write(dpmem_write),
      .dpmem_address(dpmem_address), .dpmem_wdata(dpmem_wdata),
      .dpmem_rdata(dpmem_rdata), .dpmem_resp(dpmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   function automatic logic [31:0] align(input logic [31:0] a);
      return {a[31:5], 5'b0};
   endfunction

   // Memory contents as a pure function of line address and beat index
   function automatic logic [63:0] beat_of(input logic [31:0] a, input int b);
      if (a == 32'h0000_1220) return 64'h1111_1111_1111_1111 * 64'(b + 1);
      return {a ^ 32'h5A5A_F00D, a + 32'(b) * 32'h0101_0101 + 32'h77};
   endfunction

   function automatic logic [255:0] read_line(input logic [31:0] a);
      logic [255:0] l;
      for (int b = 0; b < 4; b++) l[64*b +: 64] = beat_of(a, b);
      return l;
   endfunction

   task automatic wait_resp(input bit d, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(d ? dpmem_resp : ipmem_resp) && lat < 300);
      checks++;
      if (!(d ? dpmem_resp : ipmem_resp)) begin
         failures++;
         $display("FAIL %s_resp_timeout waited=%0d cycles, required resp within 300", d ? "d" : "i", lat);
      end
   endtask

   task automatic i_txn(input logic [31:0] a, output int lat);
      exp_t e;
      @(posedge clk); #1;
      ipmem_address = a;
      ipmem_read = 1'b1;
      e.w = 1'b0; e.addr = a; e.data = read_line(align(a));
      iq.push_back(e);
      wait_resp(1'b0, lat);
      @(posedge clk); #1;
      ipmem_read = 1'b0;
      ipmem_address = $urandom;
   endtask

   task automatic d_txn(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [255:0] wd, output int lat);
      exp_t e;
      @(posedge clk); #1;
      dpmem_address = a;
      dpmem_wdata = wd;
      dpmem_read = rd;
      dpmem_write = wr;
      e.w = wr; e.addr = a; e.data = wr ? wd : read_line(align(a));
      dq.push_back(e);
      wait_resp(1'b1, lat);
      @(posedge clk); #1;
      dpmem_read = 1'b0;
      dpmem_write = 1'b0;
      dpmem_wdata = {8{$urandom}};
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
      return l;
   endfunction

   // pmem responder: serves bursts with configurable gaps and records each completed burst
   initial begin : responder
      int idx, wait_cnt, len;
      bit in_b, give;
      logic w_c;
      logic [31:0] a_c;
      logic [255:0] d_c;
      idx = 0; wait_cnt = 0; len = 0; in_b = 1'b0; w_c = 1'b0; a_c = '0; d_c = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            idx = 0; in_b = 1'b0; pmem_resp = 1'b0;
         end else if (!(pmem_read || pmem_write)) begin
            if (in_b) chk("burst_continuous", pmem_read | pmem_write, 1);
            in_b = 1'b0; idx = 0; pmem_resp = 1'b0;
         end else begin
            if (!in_b) begin
               in_b = 1'b1; idx = 0; len = 0; wait_cnt = 0; d_c = '0;
               w_c = pmem_write; a_c = pmem_address;
               start_cyc_q.push_back(cyc);
            end else begin
               chk("burst_addr_stable", pmem_address, a_c);
               chk("burst_kind_stable", pmem_write, w_c);
            end
            chk("rd_wr_exclusive", pmem_read & pmem_write, 0);
            len++;
            give = (wait_cnt == 0) && (budget != 0);
            if (give) begin
               if (budget > 0) budget--;
               wait_cnt = gap_rand ? $urandom_range(0, 3) : gap_fixed;
               pmem_rdata = beat_of(a_c, idx);
               d_c[64*idx +: 64] = pmem_wdata;
               idx++;
               if (idx == 4) begin
                  lb_w = w_c; lb_addr = a_c; lb_data = d_c; lb_len = len;
                  in_b = 1'b0; idx = 0;
               end
            end else begin
               if (wait_cnt > 0) wait_cnt--;
               pmem_rdata = {$urandom, $urandom};
            end
            pmem_resp = give;
         end
      end
   end

   // Monitor: pops the expected entry for whichever cache gets a resp
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (ipmem_resp || dpmem_resp) chk("single_resp", ipmem_resp & dpmem_resp, 0);
         if (ipmem_resp) begin
            if (iq.size() == 0) chk("i_resp_expected", ipmem_resp, 0);
            else begin
               e = iq.pop_front();
               chk("i_rdata", ipmem_rdata, e.data);
               chk("i_burst_addr", lb_addr, align(e.addr));
               chk("i_burst_kind", lb_w, 0);
               order_q.push_back(0);
               resp_cyc_q.push_back(cyc);
            end
         end
         if (dpmem_resp) begin
            if (dq.size() == 0) chk("d_resp_expected", dpmem_resp, 0);
            else begin
               e = dq.pop_front();
               chk("d_burst_addr", lb_addr, align(e.addr));
               chk("d_burst_kind", lb_w, e.w);
               if (e.w) chk("d_write_beats", lb_data, e.data);
               else chk("d_rdata", dpmem_rdata, e.data);
               order_q.push_back(1);
               resp_cyc_q.push_back(cyc);
            end
         end
      end
   end

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      order_q.delete(); resp_cyc_q.delete(); start_cyc_q.delete();
   endtask

   function automatic int order_code();
      int ord = 0;
      foreach (order_q[k]) ord = ord * 2 + order_q[k];
      return ord;
   endfunction

   initial begin : stimulus
      int lat;
      #2 rst = 1'b0;
      #1;
      chk("rst_pmem_read", pmem_read, 0);
      chk("rst_pmem_write", pmem_write, 0);
      chk("rst_pmem_address", pmem_address, 0);
      chk("rst_pmem_wdata", pmem_wdata, 0);
      chk("rst_ipmem_resp", ipmem_resp, 0);
      chk("rst_dpmem_resp", dpmem_resp, 0);
      chk("rst_ipmem_rdata", ipmem_rdata, 0);
      chk("rst_dpmem_rdata", dpmem_rdata, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;

      // single icache read, zero-gap pmem
      i_txn(32'h0000_1234, lat);
      chk("i_latency", lat, 6);
      chk("i_burst_len", lb_len, 4);
      chk("i_pmem_addr", lb_addr, 32'h0000_1220);

      // dcache writeback with 2-cycle gaps, then read+write asserted together
      gap_fixed = 2;
      d_txn(1'b0, 1'b1, 32'h8000_0040, rand_line(), lat);
      chk("wb_burst_len", lb_len, 10);
      gap_fixed = 0;
      d_txn(1'b1, 1'b1, 32'h0000_3F7C, rand_line(), lat);
      chk("rw_both_is_write", lb_w, 1);

      // simultaneous requests out of reset: I, then D, then re-raised I
      pulse_reset();
      fork
         begin
            int l1;
            i_txn(32'h0000_4000, l1);
            i_txn(32'h0000_5020, l1);
         end
         begin
            int l2;
            d_txn(1'b1, 1'b0, 32'h0000_6040, '0, l2);
         end
      join
      chk("alt_count", order_q.size(), 3);
      chk("alt_order", order_code(), 2);
      if (start_cyc_q.size() >= 3 && resp_cyc_q.size() >= 2) begin
         chk("alt_d_grant_gap", start_cyc_q[1] - resp_cyc_q[0], 2);
         chk("alt_i_grant_gap", start_cyc_q[2] - resp_cyc_q[1], 2);
      end

      // dcache request rising mid-way through an icache burst
      order_q.delete(); resp_cyc_q.delete(); start_cyc_q.delete();
      gap_fixed = 1;
      fork
         begin
            int l1;
            i_txn(32'h0000_7060, l1);
         end
         begin
            int l2;
            repeat (4) @(posedge clk);
            d_txn(1'b1, 1'b0, 32'h0000_8080, '0, l2);
         end
      join
      chk("busy_order", order_code(), 1);
      if (start_cyc_q.size() >= 2 && resp_cyc_q.size() >= 1)
         chk("busy_d_grant_gap", start_cyc_q[1] - resp_cyc_q[0], 2);
      gap_fixed = 0;

      // asynchronous reset after two read beats
      budget = 2;
      @(posedge clk); #1;
      ipmem_address = 32'h0000_2468;
      ipmem_read = 1'b1;
      repeat (5) @(negedge clk);
      chk("pre_reset_busy", pmem_read, 1);
      rst = 1'b0;
      #1;
      chk("arst_pmem_read", pmem_read, 0);
      chk("arst_pmem_write", pmem_write, 0);
      chk("arst_ipmem_resp", ipmem_resp, 0);
      chk("arst_dpmem_resp", dpmem_resp, 0);
      ipmem_read = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); budget = -1; rst = 1'b1;
      i_txn(32'h0000_2468, lat);
      chk("post_reset_latency", lat, 6);
      chk("post_reset_len", lb_len, 4);

      // randomized concurrent traffic with random beat gaps
      gap_rand = 1'b1;
      fork
         begin
            int l1;
            for (int n = 0; n < 15; n++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               i_txn($urandom, l1);
            end
         end
         begin
            int l2, r;
            for (int n = 0; n < 15; n++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               r = $urandom_range(0, 3);
               d_txn(r == 0 || r == 3, r != 0, $urandom, rand_line(), l2);
            end
         end
      join
      repeat (4) @(posedge clk);
      chk("iq_drained", iq.size(), 0);
      chk("dq_drained", dq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
